// File: rtl/full_adder_pkg.sv
// Shared constants and helpers for the registered full adder.
// FULL_ADDER_IN_REG_EN selects the optional input register stage and so
// also changes the latency constant exported here.
package full_adder_pkg;

    // Default operand width: the classic 1-bit full adder.
    localparam int FA_DEFAULT_WIDTH = 1;

    // Clock cycles from inputs being sampled to the result appearing on the outputs.
`ifdef FULL_ADDER_IN_REG_EN
    localparam int FA_LATENCY = 2;
`else
    localparam int FA_LATENCY = 1;
`endif

    // Majority of three bits: the carry out of a single full-adder cell.
    function automatic logic fa_majority(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage : full_adder_pkg

// File: rtl/full_adder_bit.sv
// One purely combinational full-adder cell. The top chains WIDTH of these
// through their carries to form a ripple-carry adder.
module full_adder_bit
    import full_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = fa_majority(a, b, c_in);

endmodule : full_adder_bit

// File: rtl/full_adder_core.sv
// Registered WIDTH-bit ripple-carry adder: {c_out, sum} = a + b + c_in,
// presented one cycle after sampling. Defining FULL_ADDER_IN_REG_EN adds an
// input register stage on a, b and c_in, making the latency two cycles.
module full_adder_core
    import full_adder_pkg::*;
#(
    parameter int WIDTH = FA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    // Operands as seen by the adder chain (registered or direct).
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_c_in;

`ifdef FULL_ADDER_IN_REG_EN
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_c_in;

    // Input stage: capture operands every cycle, cleared by reset.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_a    <= '0;
            r_b    <= '0;
            r_c_in <= 1'b0;
        end else begin
            r_a    <= a;
            r_b    <= b;
            r_c_in <= c_in;
        end
    end

    assign w_a    = r_a;
    assign w_b    = r_b;
    assign w_c_in = r_c_in;
`else
    assign w_a    = a;
    assign w_b    = b;
    assign w_c_in = c_in;
`endif

    // Carry chain: w_carry[0] is the carry in, w_carry[WIDTH] the carry out.
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;

    assign w_carry[0] = w_c_in;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        full_adder_bit u_bit (
            .a     (w_a[gi]),
            .b     (w_b[gi]),
            .c_in  (w_carry[gi]),
            .sum   (w_sum[gi]),
            .c_out (w_carry[gi+1])
        );
    end

    logic [WIDTH-1:0] r_sum;
    logic             r_c_out;

    // Output stage: register the ripple result; reset clears it immediately.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values, independent of statement order between blocks.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_sum   <= '0;
            r_c_out <= 1'b0;
        end else begin
            r_sum   <= w_sum;
            r_c_out <= w_carry[WIDTH];
        end
    end

    assign sum   = r_sum;
    assign c_out = r_c_out;

endmodule : full_adder_core

// File: tb/tb_full_adder_core.sv
// Self-checking bench for full_adder_core at WIDTH = 1, 8 and 16.
// Honours FULL_ADDER_IN_REG_EN for the expected latency.
module tb_full_adder_core;

`ifdef FULL_ADDER_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic aresetn = 1'b0;

    logic        a1, b1, c1, s1, co1;
    logic [7:0]  a8, b8, s8;
    logic        c8, co8;
    logic [15:0] a16, b16, s16;
    logic        c16, co16;

    int n_vec = 0;
    int n_err = 0;

    // Expected {c_out, sum} for the 16-bit instance, oldest first.
    logic [16:0] sb_q[$];

    always #5 clk = ~clk;

    full_adder_core #(.WIDTH(1)) u_dut1 (
        .clk(clk), .aresetn(aresetn), .a(a1), .b(b1), .c_in(c1), .sum(s1), .c_out(co1)
    );
    full_adder_core #(.WIDTH(8)) u_dut8 (
        .clk(clk), .aresetn(aresetn), .a(a8), .b(b8), .c_in(c8), .sum(s8), .c_out(co8)
    );
    full_adder_core #(.WIDTH(16)) u_dut16 (
        .clk(clk), .aresetn(aresetn), .a(a16), .b(b16), .c_in(c16), .sum(s16), .c_out(co16)
    );

    task automatic test_reset();
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
        a16 = 16'hFFFF; b16 = 16'hFFFF; c16 = 1'b1;
        aresetn = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_vec++;
            if ({co1, s1} !== 2'b00) begin
                n_err++;
                $display("FAIL reset_w1 cycle %0d: got %b expected 00", k, {co1, s1});
            end
            n_vec++;
            if ({co8, s8} !== 9'h000) begin
                n_err++;
                $display("FAIL reset_w8 cycle %0d: got %h expected 000", k, {co8, s8});
            end
            n_vec++;
            if ({co16, s16} !== 17'h00000) begin
                n_err++;
                $display("FAIL reset_w16 cycle %0d: got %h expected 00000", k, {co16, s16});
            end
        end
        a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        a8 = '0; b8 = '0; c8 = 1'b0;
        a16 = '0; b16 = '0; c16 = 1'b0;
        aresetn = 1'b1;
    endtask

    task automatic test_exhaustive_w1();
        for (int i = 0; i < 8; i++) begin
            int s;
            @(negedge clk);
            a1 = i[0]; b1 = i[1]; c1 = i[2];
            s = i[0] + i[1] + i[2];
            repeat (4) @(negedge clk);
            n_vec++;
            if ({co1, s1} !== 2'(s)) begin
                n_err++;
                $display("FAIL exhaustive_w1 abc=%b%b%b: got c_out=%b sum=%b expected c_out=%b sum=%b",
                         i[0], i[1], i[2], co1, s1, s[1], s[0]);
            end
        end
    endtask

    task automatic test_latency_w1();
        @(negedge clk);
        a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        repeat (3) @(negedge clk);
        a1 = 1'b1;
        #1;
        n_vec++;
        if (s1 !== 1'b0) begin
            n_err++;
            $display("FAIL latency_before_edge: got sum=%b expected 0", s1);
        end
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            n_vec++;
            if (s1 !== logic'(k == LAT)) begin
                n_err++;
                $display("FAIL latency_after_edge %0d: got sum=%b expected %b", k, s1, k == LAT);
            end
        end
    endtask

    task automatic test_wrap_w8();
        logic [8:0] exp_tab [2];
        logic [16:0] stim [2];
        stim[0] = {8'hFF, 8'h01, 1'b0}; exp_tab[0] = 9'h100;
        stim[1] = {8'hFF, 8'hFF, 1'b1}; exp_tab[1] = 9'h1FF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            {a8, b8, c8} = stim[i];
            repeat (LAT) @(negedge clk);
            n_vec++;
            if ({co8, s8} !== exp_tab[i]) begin
                n_err++;
                $display("FAIL wrap_w8 case %0d: got c_out=%b sum=%h expected c_out=%b sum=%h",
                         i, co8, s8, exp_tab[i][8], exp_tab[i][7:0]);
            end
        end
    endtask

    task automatic test_midrun_reset_w8();
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h80; c8 = 1'b0;
        repeat (LAT) @(negedge clk);
        n_vec++;
        if ({co8, s8} !== 9'h100) begin
            n_err++;
            $display("FAIL midrun_before: got %h expected 100", {co8, s8});
        end
        aresetn = 1'b0;
        #1;
        n_vec++;
        if ({co8, s8} !== 9'h000) begin
            n_err++;
            $display("FAIL midrun_during: got %h expected 000", {co8, s8});
        end
        #1;
        aresetn = 1'b1;
        repeat (LAT) @(negedge clk);
        n_vec++;
        if ({co8, s8} !== 9'h100) begin
            n_err++;
            $display("FAIL midrun_after: got %h expected 100", {co8, s8});
        end
    endtask

    task automatic test_random_w16();
        sb_q.delete();
        for (int n = 0; n < 1000 + LAT; n++) begin
            @(negedge clk);
            if (sb_q.size() >= LAT) begin
                logic [16:0] exp_v;
                exp_v = sb_q.pop_front();
                n_vec++;
                if ({co16, s16} !== exp_v) begin
                    n_err++;
                    $display("FAIL random_w16 #%0d: got %h expected %h", n, {co16, s16}, exp_v);
                end
            end
            if (n < 1000) begin
                a16 = 16'($urandom);
                b16 = 16'($urandom);
                c16 = 1'($urandom);
                sb_q.push_back(17'(a16) + 17'(b16) + 17'(c16));
            end
        end
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL random_w16_drain: %0d results never compared", sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_exhaustive_w1();
        test_latency_w1();
        test_wrap_w8();
        test_midrun_reset_w8();
        test_random_w16();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule : tb_full_adder_core
